sift_window_5x5: RTL and testbench
==================================

# sift_window_5x5

- Builds the 5x5 pixel neighbourhood consumed by `DoGSum` from a raster-order 8-bit pixel stream.
- Holds four line buffers plus a 5x5 shift-register array.
- Presents the window with a `win_valid` strobe only when all 25 pixels lie inside the current frame.
- Sits between the pixel source (camera/frame-read path) and the DoG/Gaussian stage.

## Interface
Parameters:
- `IMG_WIDTH`, 640: pixels per line, ≥ 5.
- `IMG_HEIGHT`, 480: lines per frame, ≥ 5.
- `PIX_W`, 8: pixel width.

Ports:
- `clk`  in  1  the single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `pix_valid`  in  1  `pix_in` accepted this cycle; no backpressure.
- `pix_in`  in  PIX_W  pixel, raster order.
- `sof`  in  1  qualified by `pix_valid`; marks pixel (0,0).
- `win`  out  25*PIX_W  window. `ImageRegR_C` (R,C = 1..5) is at `win[((R-1)*5+(C-1))*PIX_W +: PIX_W]`.
- `win_valid`  out  1  `win` holds a complete in-frame window.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the next accepted pixel.
  - Each accepted pixel increments `col`.
  - At `IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At the last pixel of the frame, both counters wrap to 0.
- `sof` with `pix_valid`: the pixel is treated as (0,0) regardless of counter state; the counters restart (mid-frame resync). `sof` without `pix_valid` is ignored.
- Line buffers LB0..LB3, each IMG_WIDTH deep, are read-before-write at address `col`.
  - LB0 returns row r-1, ..., LB3 returns row r-4.
  - On accept, `pix_in`→LB0[col], LB0 old→LB1[col], and so on down the chain.
- Window columns shift left on each accept.
  - Column 5 is loaded from {LB3, LB2, LB1, LB0, `pix_in`} into rows 1..5.
  - Row 1 is the oldest line; column 1 is the oldest pixel.
- After accepting pixel (r,c), `ImageRegR_C` equals pixel (r-5+R, c-5+C).
- `win_valid` = 1 for the cycle after accepting (r,c) with r ≥ 4 and c ≥ 4. The window centre is then (r-2, c-2).
- No `pix_valid`: `win` and `win_valid` do not change (window held), except that `win_valid` drops to 0.
- Window count per frame: (IMG_WIDTH-4)*(IMG_HEIGHT-4). No border windows are produced.
- Windows that straddle a line wrap (c < 4) contain stale columns. This is allowed, but `win_valid` is 0 for them.

## Timing
- Latency: exactly 1 cycle from an accepting edge to `win`/`win_valid` update.
- Throughput: one pixel per cycle, sustained indefinitely; arbitrary `pix_valid` gaps are allowed.
- Reset (`rst`=0, asynchronous):
  - `col`, `row`, every `win` register and `win_valid` go to 0 immediately.
  - Line-buffer contents are not cleared.
  - First post-reset pixel is (0,0) even without `sof`.
- Reset mid-frame: frame is abandoned; no `win_valid` until row 4, col 4 of the new count.
- Line-buffer RAM has combinational read (distributed RAM), so there is no extra read latency.

## Configuration
- `SIFT_WIN_COORD_EN` defined: adds outputs `win_x` [$clog2(IMG_WIDTH)-1:0] and `win_y` [$clog2(IMG_HEIGHT)-1:0].
  - Both are registered alongside `win` and equal the window-centre coordinates (c-2, r-2).
  - Both reset to 0 and hold between valids.
- Not defined: the ports and their registers are absent; all other behaviour is identical.

## Structure
- Package `sift_pkg` holds `PIX_W` default 8, `WIN_SIZE` = 5, `NUM_LB` = 4, and the `win` slice-index function shared with `DoGSum` wrappers.
- Sub-module `sift_line_buffer`: one IMG_WIDTH x PIX_W RAM with read-before-write at a shared address.
  - Four instances are cascaded.
  - Top level holds the counters, the shift array and the valid logic.

## Test plan
All tests use IMG_WIDTH=8, IMG_HEIGHT=6 and pixel value (r<<4)|c. In 1–4, `pix_valid` is held high with `sof` on the first pixel.
1. Stream one frame → first `win_valid` exactly 1 cycle after pixel (4,4) is accepted, with `ImageReg1_1`=0x00, `ImageReg3_3`=0x22, `ImageReg5_5`=0x44.
2. Same frame → exactly 8 `win_valid` pulses. The last window, after (5,7), has `ImageReg1_1`=0x13 and `ImageReg5_5`=0x57.
3. Two back-to-back frames → second frame yields identical 8 windows; no `win_valid` during rows 0–3 of frame 2.
4. `pix_valid` toggled 1-0-1-0 → same 8 windows in order; `win_valid` never high on a cycle following `pix_valid`=0.
5. `rst` pulsed low after pixel (4,5) → `win_valid` and `win` are 0 immediately; the next 48 pixels without `sof` give exactly 8 windows.
6. `sof` reasserted at pixel (2,3) of a frame → counters restart, and the next `win_valid` comes only after 4*8+4 further pixels. With `SIFT_WIN_COORD_EN` defined, the first window has `win_x`=2, `win_y`=2.

Source files
------------

// File: rtl/sift_pkg.sv
// Shared constants and the window slice-index helper for the SIFT 5x5 window
// builder and the DoGSum wrappers that consume its flattened window bus.
package sift_pkg;

    // Default pixel width when the instantiating level does not override it.
    localparam int DEFAULT_PIX_W = 8;

    // Window is WIN_SIZE x WIN_SIZE; NUM_LB line buffers supply the older rows.
    localparam int WIN_SIZE = 5;
    localparam int NUM_LB   = WIN_SIZE - 1;

    // LSB of ImageRegR_C (R,C = 1..WIN_SIZE) inside the flattened window bus.
    // Row 1 is the oldest line, column 1 the oldest pixel.
    function automatic int winSliceLsb(input int r, input int c, input int pixW);
        return ((r - 1) * WIN_SIZE + (c - 1)) * pixW;
    endfunction

endpackage : sift_pkg

// File: rtl/sift_line_buffer.sv
// One line of pixel storage: DEPTH x PIX_W RAM, combinational read and
// synchronous write at a shared address, so a read sees the value from the
// previous line before this cycle's write replaces it.
module sift_line_buffer
    import sift_pkg::*;
#(
    parameter int  DEPTH = 640,
    parameter int  PIX_W = DEFAULT_PIX_W,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wrData,
    output logic [PIX_W-1:0] rdData
);

    logic [PIX_W-1:0] mem [DEPTH];

    // Distributed-RAM style read: old contents are visible in the same cycle.
    assign rdData = mem[addr];

    // Write the incoming pixel of the current line over the previous line's pixel.
    // NOTE: storage arrays get no reset; clearing them would prevent RAM inference
    // and the window logic never exposes unwritten entries as valid.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[addr] <= wrData;
        end
    end

endmodule : sift_line_buffer

// File: rtl/sift_window_5x5.sv
// Builds the 5x5 neighbourhood for DoGSum from a raster-order pixel stream.
// Four cascaded line buffers provide rows r-1..r-4; a 5x5 register array
// shifts left on every accepted pixel, and win_valid flags windows that lie
// completely inside the frame.
// Optional feature: define SIFT_WIN_COORD_EN to add the window-centre
// coordinate outputs win_x / win_y.
module sift_window_5x5
    import sift_pkg::*;
#(
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    parameter int  PIX_W      = DEFAULT_PIX_W,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pix_valid,
    input  logic [PIX_W-1:0]                    pix_in,
    input  logic                                sof,
    output logic [WIN_SIZE*WIN_SIZE*PIX_W-1:0]  win,
    output logic                                win_valid
`ifdef SIFT_WIN_COORD_EN
    ,
    output logic [CW-1:0]                       win_x,
    output logic [RW-1:0]                       win_y
`endif
);

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position the pixel on the bus is treated as, and where the count goes next.
    logic [CW-1:0] curCol;
    logic [RW-1:0] curRow;
    logic [CW-1:0] nextCol;
    logic [RW-1:0] nextRow;

    // The accepted pixel completes an in-frame window.
    logic          isWindow;

    // Line-buffer chain and the column about to enter the window.
    logic [PIX_W-1:0] lbIn   [NUM_LB];
    logic [PIX_W-1:0] lbOut  [NUM_LB];
    logic [PIX_W-1:0] newCol [WIN_SIZE];

    // Window registers, [row][col] with index 0 the oldest line / oldest pixel.
    logic [PIX_W-1:0] imageReg [WIN_SIZE][WIN_SIZE];

    // Resolve the pixel's raster position (sof forces a restart at (0,0)) and
    // compute the following position, wrapping at line and frame end. The
    // result only takes effect on pix_valid, so a lone sof is ignored.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned and infers a latch.
    always_comb begin
        curCol  = col;
        curRow  = row;
        if (sof) begin
            curCol = '0;
            curRow = '0;
        end
        nextCol = curCol + CW'(1);
        nextRow = curRow;
        if (curCol == CW'(IMG_WIDTH - 1)) begin
            nextCol = '0;
            nextRow = (curRow == RW'(IMG_HEIGHT - 1)) ? '0 : curRow + RW'(1);
        end
    end

    assign isWindow = (curRow >= RW'(WIN_SIZE - 1)) && (curCol >= CW'(WIN_SIZE - 1));

    // Advance the raster counters on every accepted pixel.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            col <= nextCol;
            row <= nextRow;
        end
    end

    // Cascade: LB0 takes the new pixel, each later buffer takes its
    // predecessor's displaced value, so LBk holds row r-1-k at column col.
    always_comb begin
        lbIn[0] = pix_in;
        for (int i = 1; i < NUM_LB; i++) begin
            lbIn[i] = lbOut[i-1];
        end
    end

    for (genvar gi = 0; gi < NUM_LB; gi++) begin : gLineBuf
        sift_line_buffer #(
            .DEPTH (IMG_WIDTH),
            .PIX_W (PIX_W)
        ) uLineBuf (
            .clk    (clk),
            .wrEn   (pix_valid),
            .addr   (curCol),
            .wrData (lbIn[gi]),
            .rdData (lbOut[gi])
        );
    end

    // Column entering the window: oldest line (LB3) at the top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < NUM_LB; r++) begin
            newCol[r] = lbOut[NUM_LB-1-r];
        end
        newCol[WIN_SIZE-1] = pix_in;
    end

    // Shift the window one column left and load the new column on the right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    imageReg[r][c] <= '0;
                end
            end
        end else if (pix_valid) begin
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE - 1; c++) begin
                    imageReg[r][c] <= imageReg[r][c+1];
                end
                imageReg[r][WIN_SIZE-1] <= newCol[r];
            end
        end
    end

    // Strobe for exactly the cycle after a pixel that completes an in-frame window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
        end else begin
            win_valid <= pix_valid && isWindow;
        end
    end

`ifdef SIFT_WIN_COORD_EN
    // Window-centre coordinates, captured with each valid window and held between them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_x <= '0;
            win_y <= '0;
        end else if (pix_valid && isWindow) begin
            win_x <= curCol - CW'(2);
            win_y <= curRow - RW'(2);
        end
    end
`endif

    // Flatten the register array onto the window bus in ImageRegR_C order.
    always_comb begin
        win = '0;
        for (int r = 0; r < WIN_SIZE; r++) begin
            for (int c = 0; c < WIN_SIZE; c++) begin
                win[winSliceLsb(r + 1, c + 1, PIX_W) +: PIX_W] = imageReg[r][c];
            end
        end
    end

endmodule : sift_window_5x5

// File: tb/tb_sift_window_5x5.sv
// Self-checking bench for sift_window_5x5 on an 8x6 frame with pixel value
// (r<<4)|c. Expected windows are built from the bench's own copy of the
// frame and queued as pixels are driven; the monitor pops and compares them.
module tb_sift_window_5x5;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int PW   = 8;
    localparam int WINB = 25 * PW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pix_valid = 1'b0;
    logic            sof = 1'b0;
    logic [PW-1:0]   pix_in = '0;
    logic [WINB-1:0] win;
    logic            win_valid;
`ifdef SIFT_WIN_COORD_EN
    logic [2:0]      win_x;
    logic [2:0]      win_y;
`endif

    sift_window_5x5 #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIX_W      (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_valid (pix_valid),
        .pix_in    (pix_in),
        .sof       (sof),
        .win       (win),
        .win_valid (win_valid)
`ifdef SIFT_WIN_COORD_EN
        ,
        .win_x     (win_x),
        .win_y     (win_y)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WINB-1:0] win;
        int              x;
        int              y;
    } winExp_t;

    int              checkCount = 0;
    int              passCount  = 0;
    winExp_t         expQ[$];
    logic [WINB-1:0] seenWins[$];
    logic [WINB-1:0] refWins[$];
    logic [PW-1:0]   pixMem [H][W];
    int              tr = 0;
    int              tc = 0;
    int              sinceSof = 0;
    int              firstSince = -1;
    int              firstX = -1;
    int              firstY = -1;
    bit              monEn = 1'b0;
    logic [WINB-1:0] prevWin = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] imgReg(input logic [WINB-1:0] w, input int r, input int c);
        logic [WINB-1:0] t;
        t = w >> (((r - 1) * 5 + (c - 1)) * PW);
        return t[PW-1:0];
    endfunction

    // Drive one accepted pixel; record it in the frame copy and queue the
    // window it completes, if it completes one.
    task automatic sendPix(input logic [PW-1:0] val, input bit doSof);
        winExp_t e;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_in    = val;
        sof       = doSof;
        if (doSof) begin
            tr = 0;
            tc = 0;
            sinceSof = 0;
        end else begin
            sinceSof++;
        end
        pixMem[tr][tc] = val;
        if (tr >= 4 && tc >= 4) begin
            e.win = '0;
            for (int r = 1; r <= 5; r++)
                for (int c = 1; c <= 5; c++)
                    e.win[((r - 1) * 5 + (c - 1)) * PW +: PW] = pixMem[tr - 5 + r][tc - 5 + c];
            e.x = tc - 2;
            e.y = tr - 2;
            expQ.push_back(e);
        end
        if (tc == W - 1) begin
            tc = 0;
            tr = (tr == H - 1) ? 0 : tr + 1;
        end else begin
            tc++;
        end
    endtask

    task automatic sendAuto(input bit doSof);
        logic [PW-1:0] v;
        v = PW'((tr << 4) | tc);
        sendPix(v, doSof);
    endtask

    // Idle cycles carry junk data and a random sof, both of which must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_in    = PW'($urandom);
            sof       = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sendFrame(input bit withSof, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                sendPix(PW'((r << 4) | c), withSof && r == 0 && c == 0);
                if (gaps) idle(1);
            end
    endtask

    // Monitor: sample one time unit after each rising edge.
    initial begin
        winExp_t e;
        bit      hasExp;
        forever begin
            @(posedge clk);
            #1;
            if (monEn) begin
                if (!pix_valid) begin
                    check("gapValid", win_valid, 1'b0);
                    check("gapHold", win, prevWin);
                end else begin
                    hasExp = (expQ.size() > 0);
                    check("winValid", win_valid, hasExp);
                    if (hasExp) begin
                        e = expQ.pop_front();
                        if (win_valid) begin
                            check("winData", win, e.win);
`ifdef SIFT_WIN_COORD_EN
                            check("winX", win_x, e.x);
                            check("winY", win_y, e.y);
`endif
                        end
                    end
                    if (win_valid) begin
                        seenWins.push_back(win);
                        if (firstSince < 0) begin
                            firstSince = sinceSof;
`ifdef SIFT_WIN_COORD_EN
                            firstX = int'(win_x);
                            firstY = int'(win_y);
`endif
                        end
                    end
                end
            end
            prevWin = win;
        end
    end

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rstValid", win_valid, 1'b0);
        check("rstWin", win, '0);
        rst = 1'b1;
        @(negedge clk);
        monEn = 1'b1;
        idle(2);

        // Single frame: first window contents and the last window
        seenWins.delete();
        sendFrame(1'b1, 1'b0);
        idle(3);
        check("t2Count", seenWins.size(), 8);
        check("t2Drain", expQ.size(), 0);
        if (seenWins.size() >= 8) begin
            check("t1Reg11", imgReg(seenWins[0], 1, 1), 8'h00);
            check("t1Reg33", imgReg(seenWins[0], 3, 3), 8'h22);
            check("t1Reg55", imgReg(seenWins[0], 5, 5), 8'h44);
            check("t2Reg11", imgReg(seenWins[7], 1, 1), 8'h13);
            check("t2Reg55", imgReg(seenWins[7], 5, 5), 8'h57);
        end
        refWins = seenWins;

        // Back-to-back frames
        seenWins.delete();
        sendFrame(1'b1, 1'b0);
        sendFrame(1'b1, 1'b0);
        idle(3);
        check("t3Count", seenWins.size(), 16);
        check("t3Drain", expQ.size(), 0);
        if (seenWins.size() == 16 && refWins.size() == 8)
            for (int i = 0; i < 8; i++) begin
                check("t3Frame1", seenWins[i], refWins[i]);
                check("t3Frame2", seenWins[8 + i], refWins[i]);
            end

        // Alternating pix_valid
        seenWins.delete();
        sendFrame(1'b1, 1'b1);
        idle(3);
        check("t4Count", seenWins.size(), 8);
        check("t4Drain", expQ.size(), 0);
        if (seenWins.size() == 8 && refWins.size() == 8)
            for (int i = 0; i < 8; i++) check("t4Order", seenWins[i], refWins[i]);

        // Reset after pixel (4,5), then a full frame without sof
        seenWins.delete();
        for (int i = 0; i < 4 * W + 6; i++)
            sendPix(PW'(((i / W) << 4) | (i % W)), i == 0);
        @(negedge clk);
        pix_valid = 1'b0;
        sof = 1'b0;
        check("t5PreCount", seenWins.size(), 2);
        monEn = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5RstValid", win_valid, 1'b0);
        check("t5RstWin", win, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tr = 0;
        tc = 0;
        monEn = 1'b1;
        seenWins.delete();
        for (int i = 0; i < W * H; i++) sendAuto(1'b0);
        idle(3);
        check("t5Count", seenWins.size(), 8);
        check("t5Drain", expQ.size(), 0);
        if (seenWins.size() == 8 && refWins.size() == 8)
            for (int i = 0; i < 8; i++) check("t5Order", seenWins[i], refWins[i]);

        // sof resync at pixel (2,3)
        seenWins.delete();
        for (int i = 0; i < 2 * W + 3; i++)
            sendPix(PW'(((i / W) << 4) | (i % W)), i == 0);
        firstSince = -1;
        sendPix(8'h23, 1'b1);
        for (int i = 0; i < W * H - 1; i++) sendAuto(1'b0);
        idle(3);
        check("t6Count", seenWins.size(), 8);
        check("t6Drain", expQ.size(), 0);
        check("t6Latency", firstSince, 4 * W + 4);
        if (seenWins.size() > 0) check("t6SofPix", imgReg(seenWins[0], 1, 1), 8'h23);
`ifdef SIFT_WIN_COORD_EN
        check("t6WinX", firstX, 2);
        check("t6WinY", firstY, 2);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_sift_window_5x5
